// File: rtl/dbg_gpio_pkg.sv
// -----------------------------------------------------------------------------
// dbg_gpio_pkg
// Shared types and default widths for the debug-GPIO generator.
//   dbg_mode_t          : per-channel operating mode
//   DBG_DIV_W_DEF       : default width of the toggle event divider
//   DBG_STRETCH_W_DEF   : default width of the pulse-stretch length
// -----------------------------------------------------------------------------
package dbg_gpio_pkg;

  typedef enum logic [1:0] {
    DBG_OFF    = 2'd0,
    DBG_LEVEL  = 2'd1,
    DBG_TOGGLE = 2'd2,
    DBG_PULSE  = 2'd3
  } dbg_mode_t;

  localparam int DBG_DIV_W_DEF     = 8;
  localparam int DBG_STRETCH_W_DEF = 8;

endpackage

// File: rtl/dbg_gpio_ch.sv
// -----------------------------------------------------------------------------
// dbg_gpio_ch
// One debug-GPIO channel: holds its own configuration, the toggle event
// counter, the pulse-stretch counter and the registered output pin.
// Ports:
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   i_we             one-cycle config write strobe for this channel
//   i_sel/i_mode/i_div/i_len  configuration values captured on i_we
//   i_rise           rising-edge pulse of the currently selected source
//   i_lvl            level of the currently selected source
//   o_sel            current source select (drives the mux in the top)
//   o_out            registered debug output
// -----------------------------------------------------------------------------
module dbg_gpio_ch
  import dbg_gpio_pkg::*;
#(
  parameter int SEL_W     = 3,
  parameter int DIV_W     = DBG_DIV_W_DEF,
  parameter int STRETCH_W = DBG_STRETCH_W_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_we,
  input  logic [SEL_W-1:0]     i_sel,
  input  logic [1:0]           i_mode,
  input  logic [DIV_W-1:0]     i_div,
  input  logic [STRETCH_W-1:0] i_len,
  input  logic                 i_rise,
  input  logic                 i_lvl,
  output logic [SEL_W-1:0]     o_sel,
  output logic                 o_out
);

  dbg_mode_t            r_mode, w_mode_next;
  logic [SEL_W-1:0]     r_sel, w_sel_next;
  logic [DIV_W-1:0]     r_div, w_div_next;
  logic [STRETCH_W-1:0] r_len, w_len_next;
  logic [DIV_W-1:0]     r_cnt, w_cnt_next;
  logic [STRETCH_W-1:0] r_st, w_st_next;
  logic                 r_out, w_out_next;

  always_comb begin
    w_mode_next = r_mode;
    w_sel_next  = r_sel;
    w_div_next  = r_div;
    w_len_next  = r_len;
    w_cnt_next  = r_cnt;
    w_st_next   = r_st;
    w_out_next  = r_out;

    if (i_we) begin
      // A write restarts the channel cleanly; any event arriving on the
      // same edge belongs to the old configuration and is dropped.
      w_mode_next = dbg_mode_t'(i_mode);
      w_sel_next  = i_sel;
      w_div_next  = i_div;
      w_len_next  = i_len;
      w_cnt_next  = '0;
      w_st_next   = '0;
      w_out_next  = 1'b0;
    end else begin
      case (r_mode)
        DBG_OFF: begin
          w_out_next = 1'b0;
        end
        DBG_LEVEL: begin
          w_out_next = i_lvl;
        end
        DBG_TOGGLE: begin
          if (i_rise) begin
            if (r_cnt == r_div) begin
              w_out_next = ~r_out;
              w_cnt_next = '0;
            end else begin
              w_cnt_next = r_cnt + DIV_W'(1);
            end
          end
        end
        DBG_PULSE: begin
          // Reloading on every rise makes the pulse retriggerable: the
          // output stays high LEN+1 cycles past the most recent event.
          if (i_rise) begin
            w_out_next = 1'b1;
            w_st_next  = r_len;
          end else if (r_out) begin
            if (r_st == '0) begin
              w_out_next = 1'b0;
            end else begin
              w_st_next = r_st - STRETCH_W'(1);
            end
          end
        end
        default: begin
          w_out_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mode <= DBG_OFF;
      r_sel  <= '0;
      r_div  <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
      r_st   <= '0;
      r_out  <= 1'b0;
    end else begin
      r_mode <= w_mode_next;
      r_sel  <= w_sel_next;
      r_div  <= w_div_next;
      r_len  <= w_len_next;
      r_cnt  <= w_cnt_next;
      r_st   <= w_st_next;
      r_out  <= w_out_next;
    end
  end

  assign o_sel = r_sel;
  assign o_out = r_out;

endmodule

// File: rtl/dbg_gpio_gen.sv
// -----------------------------------------------------------------------------
// dbg_gpio_gen
// Parametrised debug-GPIO generator. Each of N_CH output pins follows one of
// N_SRC event sources in OFF / LEVEL / divided TOGGLE / retriggerable PULSE
// mode. The sources go through a shared two-stage pipeline used for rising
// edge detection; each channel picks its source through a mux.
// Ports:
//   CLK       system clock
//   RESET_N   synchronous active-low reset
//   SRC       event sources, synchronous to CLK
//   CFG_WE    one-cycle config write strobe
//   CFG_CH    channel written (indices >= N_CH are ignored)
//   CFG_SEL   source select (selects >= N_SRC read as constant 0)
//   CFG_MODE  dbg_mode_t
//   CFG_DIV   toggle every CFG_DIV+1 rising edges
//   CFG_LEN   pulse high for CFG_LEN+1 cycles
//   GPIO_OUT  registered debug outputs
// -----------------------------------------------------------------------------
module dbg_gpio_gen
  import dbg_gpio_pkg::*;
#(
  parameter  int N_CH      = 4,
  parameter  int N_SRC     = 8,
  parameter  int DIV_W     = DBG_DIV_W_DEF,
  parameter  int STRETCH_W = DBG_STRETCH_W_DEF,
  localparam int SEL_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [N_SRC-1:0]     SRC,
  input  logic                 CFG_WE,
  input  logic [CH_W-1:0]      CFG_CH,
  input  logic [SEL_W-1:0]     CFG_SEL,
  input  logic [1:0]           CFG_MODE,
  input  logic [DIV_W-1:0]     CFG_DIV,
  input  logic [STRETCH_W-1:0] CFG_LEN,
  output logic [N_CH-1:0]      GPIO_OUT
);

  // Every encodable select value gets a mux input; the unused ones are tied
  // low so an out-of-range select behaves like a silent source.
  localparam int N_PAD = 1 << SEL_W;

  logic [N_SRC-1:0] r_src_q;
  logic [N_SRC-1:0] r_src_qq;
  logic [N_SRC-1:0] w_rise;
  logic [N_PAD-1:0] w_lvl_pad;
  logic [N_PAD-1:0] w_rise_pad;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_src_q  <= '0;
      r_src_qq <= '0;
    end else begin
      r_src_q  <= SRC;
      r_src_qq <= r_src_q;
    end
  end

  assign w_rise = r_src_q & ~r_src_qq;

  genvar gi;
  generate
    for (gi = 0; gi < N_PAD; gi++) begin : g_pad
      if (gi < N_SRC) begin : g_real
        assign w_lvl_pad[gi]  = r_src_q[gi];
        assign w_rise_pad[gi] = w_rise[gi];
      end else begin : g_zero
        assign w_lvl_pad[gi]  = 1'b0;
        assign w_rise_pad[gi] = 1'b0;
      end
    end

    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [SEL_W-1:0] w_sel;
      logic             w_we;
      logic             w_out;

      assign w_we = CFG_WE && (CFG_CH == CH_W'(gi));

      dbg_gpio_ch #(
        .SEL_W     (SEL_W),
        .DIV_W     (DIV_W),
        .STRETCH_W (STRETCH_W)
      ) u_ch (
        .i_clk   (CLK),
        .i_rst_n (RESET_N),
        .i_we    (w_we),
        .i_sel   (CFG_SEL),
        .i_mode  (CFG_MODE),
        .i_div   (CFG_DIV),
        .i_len   (CFG_LEN),
        .i_rise  (w_rise_pad[w_sel]),
        .i_lvl   (w_lvl_pad[w_sel]),
        .o_sel   (w_sel),
        .o_out   (w_out)
      );

      assign GPIO_OUT[gi] = w_out;
    end
  endgenerate

endmodule

// File: tb/tb_dbg_gpio_gen.sv
// -----------------------------------------------------------------------------
// tb_dbg_gpio_gen
// Directed bench for dbg_gpio_gen. Two instances share the config bus:
// u_dut_a is the default build (N_SRC=8), u_dut_b is an N_SRC=6 build whose
// selects 6 and 7 are out of range. Inputs are driven 1 ns after a rising
// edge; outputs are read 1 ns after the edge that updated them.
// -----------------------------------------------------------------------------
module tb_dbg_gpio_gen;
  import dbg_gpio_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] src;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [2:0] cfg_sel;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_div;
  logic [7:0] cfg_len;
  logic [3:0] gpio_a;
  logic [3:0] gpio_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dbg_gpio_gen #(.N_CH(4), .N_SRC(8), .DIV_W(8), .STRETCH_W(8)) u_dut_a (
    .CLK(clk), .RESET_N(rst_n), .SRC(src), .CFG_WE(cfg_we), .CFG_CH(cfg_ch),
    .CFG_SEL(cfg_sel), .CFG_MODE(cfg_mode), .CFG_DIV(cfg_div),
    .CFG_LEN(cfg_len), .GPIO_OUT(gpio_a)
  );

  dbg_gpio_gen #(.N_CH(4), .N_SRC(6), .DIV_W(8), .STRETCH_W(8)) u_dut_b (
    .CLK(clk), .RESET_N(rst_n), .SRC(src[5:0]), .CFG_WE(cfg_we), .CFG_CH(cfg_ch),
    .CFG_SEL(cfg_sel), .CFG_MODE(cfg_mode), .CFG_DIV(cfg_div),
    .CFG_LEN(cfg_len), .GPIO_OUT(gpio_b)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [2:0] sel,
                           input dbg_mode_t mode, input logic [7:0] div,
                           input logic [7:0] len);
    cfg_ch   = ch;
    cfg_sel  = sel;
    cfg_mode = mode;
    cfg_div  = div;
    cfg_len  = len;
    cfg_we   = 1'b1;
    tick(1);
    cfg_we   = 1'b0;
    $display("cfg ch=%0d sel=%0d mode=%s div=%0d len=%0d", ch, sel, mode.name(), div, len);
  endtask

  // One-cycle pulse on src[b]; ch output checked one and two edges later.
  task automatic src_pulse(input int b, input int ch, input logic exp_mid,
                           input logic exp_end, input string tag);
    src[b] = 1'b1;
    tick(1);
    check_eq({tag, "_mid"}, gpio_a[ch], exp_mid);
    src[b] = 1'b0;
    tick(1);
    check_eq({tag, "_end"}, gpio_a[ch], exp_end);
    $display("pulse src%0d ch%0d out=%0b", b, ch, gpio_a[ch]);
  endtask

  // Pulse on src[4] at step 0 and optionally again at step `second`;
  // ch1 expected high from step 2 through step last_hi.
  task automatic run_pulse(input int second, input int last_hi, input string tag);
    src[4] = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      tick(1);
      src[4] = (j == second);
      check_eq(tag, gpio_a[1], (j >= 2 && j <= last_hi));
    end
    $display("stretch %s done", tag);
  endtask

  initial begin
    rst_n    = 1'b0;
    src      = 8'hFF;
    cfg_we   = 1'b0;
    cfg_ch   = '0;
    cfg_sel  = '0;
    cfg_mode = '0;
    cfg_div  = '0;
    cfg_len  = '0;

    // Reset held with all sources high.
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_eq("rst_a", gpio_a, 4'h0);
      check_eq("rst_b", gpio_b, 4'h0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      src = (i % 2 == 0) ? 8'hFF : 8'h00;
      tick(1);
      check_eq("post_rst_off", gpio_a, 4'h0);
    end
    src = 8'h00;
    tick(2);
    $display("reset phase done");

    // Toggle DIV=0: every rise toggles.
    cfg_write(2'd0, 3'd2, DBG_TOGGLE, 8'd0, 8'd0);
    for (int i = 1; i <= 4; i++)
      src_pulse(2, 0, logic'((i - 1) % 2), logic'(i % 2), "tog_div0");

    // Toggle DIV=3: one toggle every 4 rises.
    cfg_write(2'd0, 3'd2, DBG_TOGGLE, 8'd3, 8'd0);
    check_eq("tog_cfg_clear", gpio_a[0], 1'b0);
    for (int i = 1; i <= 8; i++)
      src_pulse(2, 0, logic'(((i - 1) / 4) % 2), logic'((i / 4) % 2), "tog_div3");

    // Pulse stretch LEN=5, single event then retriggered event.
    cfg_write(2'd1, 3'd4, DBG_PULSE, 8'd0, 8'd5);
    run_pulse(-1, 7, "pulse_single");
    run_pulse(3, 10, "pulse_retrig");

    // Level mode; build B has no sources 6 and 7.
    cfg_write(2'd0, 3'd0, DBG_OFF, 8'd0, 8'd0);
    cfg_write(2'd1, 3'd0, DBG_OFF, 8'd0, 8'd0);
    cfg_write(2'd2, 3'd7, DBG_LEVEL, 8'd0, 8'd0);
    cfg_write(2'd3, 3'd6, DBG_LEVEL, 8'd0, 8'd0);
    src = 8'hFF;
    for (int j = 1; j <= 14; j++) begin
      tick(1);
      src = (j < 10) ? 8'hFF : 8'h00;
      check_eq("level_a", gpio_a, (j >= 2 && j <= 11) ? 4'b1100 : 4'b0000);
      check_eq("level_b_badsel", gpio_b, 4'h0);
    end
    $display("level phase done");

    // Write collides with a rise: event dropped, out and cnt cleared.
    cfg_write(2'd2, 3'd0, DBG_OFF, 8'd0, 8'd0);
    cfg_write(2'd3, 3'd0, DBG_OFF, 8'd0, 8'd0);
    cfg_write(2'd0, 3'd2, DBG_TOGGLE, 8'd0, 8'd0);
    src_pulse(2, 0, 1'b0, 1'b1, "coll_pre");
    src[2] = 1'b1;
    tick(1);
    src[2] = 1'b0;
    cfg_write(2'd0, 3'd2, DBG_TOGGLE, 8'd1, 8'd0);
    check_eq("coll_out", gpio_a[0], 1'b0);
    tick(2);
    check_eq("coll_hold", gpio_a[0], 1'b0);
    src_pulse(2, 0, 1'b0, 1'b0, "coll_first");
    src_pulse(2, 0, 1'b0, 1'b1, "coll_second");

    // Reset in the middle of a long pulse.
    cfg_write(2'd1, 3'd4, DBG_PULSE, 8'd0, 8'd200);
    src[4] = 1'b1;
    tick(1);
    src[4] = 1'b0;
    tick(1);
    check_eq("rst_mid_start", gpio_a[1], 1'b1);
    tick(48);
    check_eq("rst_mid_pre", gpio_a[1], 1'b1);
    rst_n = 1'b0;
    tick(1);
    check_eq("rst_mid_drop", gpio_a[1], 1'b0);
    check_eq("rst_mid_all_b", gpio_b, 4'h0);
    rst_n = 1'b1;
    src[4] = 1'b1;
    tick(1);
    src[4] = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick(1);
      check_eq("rst_mid_cfg_off", gpio_a, 4'h0);
    end
    $display("reset-mid-pulse phase done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
